send_slot_arbiter: RTL and testbench
====================================

// Module: send_slot_arbiter
// PURPOSE
//  Shares one serial send path between N_REQ requesters. Each requester raises ready when it has a frame.
//  Round-robin arbiter grants one requester at a time and holds the grant until that ready drops.
//  After every release it enforces a guard gap of INTERVAL clk cycles before the next grant.
//  Sits between the frame builders and the shared transmitter; ready_waited drives the transmitter start.
// PARAMETERS
//  N_REQ     4     number of requesters, 2..16
//  ID_W      2     width of grant_id; must equal clog2(N_REQ)
//  MAX_HOLD  1024  max grant length in clk cycles; used only with SEND_ARB_HOLD_TIMEOUT_EN
// PORTS
//  clk           in   1      system clock
//  rst_n         in   1      reset; synchronous, active-low
//  INTERVAL      in   32     guard gap in clk cycles; latched when GAP is entered
//  req_ready     in   N_REQ  per-requester send request, level
//  grant         out  N_REQ  one-hot grant, registered
//  grant_id      out  ID_W   index of granted requester, registered
//  ready_waited  out  1      req_ready[grant_id] & (state==GRANT), combinational; transmitter start/hold
//  busy          out  1      high in GRANT or GAP, registered
//  hold_timeout  out  1      1-cycle pulse on forced release (macro only; else tied 0)
// BEHAVIOUR
//  Reset (rst_n low at clk edge): state=IDLE, grant=0, grant_id=0, busy=0, hold_timeout=0.
//   Also gap counter=0 and last_id=N_REQ-1, so the first search starts at 0.
//   Reset mid-GRANT or mid-GAP aborts immediately; no gap is served after reset.
//  States: IDLE, GRANT, GAP (one-hot encoding permitted).
//  IDLE: if |req_ready, pick winner = first set bit searching last_id+1 upward, wrapping past N_REQ-1 to 0.
//   Next edge: grant[winner]=1, grant_id=winner, last_id=winner, busy=1, state=GRANT.
//   Latency from req_ready high in IDLE to grant high: 1 cycle.
//  GRANT: grant held stable. ready of non-granted requesters is ignored.
//   When req_ready[grant_id]==0: next edge grant=0, state=GAP, gap counter=0, INTERVAL latched.
//   A grant always lasts >=1 cycle, even if ready drops in the first GRANT cycle.
//   Every grant is followed by GAP.
//  GAP: gap counter increments each cycle. Exit to IDLE at the edge where counter==max(INTERVAL_latched,1)-1.
//   GAP length = max(INTERVAL,1) cycles. busy falls with the exit to IDLE.
//   Changes to INTERVAL during GAP take effect on the next GAP only.
//  Gap counter is 32 bits and never wraps; INTERVAL=0xFFFFFFFF is legal.
//  From GAP exit to next grant: min 1 IDLE cycle. Total release->grant = max(INTERVAL,1)+1 cycles.
//  Requesters that raise ready during GRANT or GAP wait; a request is never lost while held high.
//  Fairness: with all requesters continuously asserting ready, the grant order is 0,1,..,N_REQ-1,0,...
//  Simultaneous requests in IDLE are resolved solely by round-robin order; no fixed priority.
// CONFIGURATION
//  SEND_ARB_HOLD_TIMEOUT_EN defined:
//   A hold counter runs in GRANT. If ready is still high after MAX_HOLD cycles:
//   forced GRANT->GAP, hold_timeout pulses 1 cycle (same edge grant clears).
//   The timed-out requester is masked from arbitration until its req_ready is seen low.
//  SEND_ARB_HOLD_TIMEOUT_EN undefined:
//   No hold counter; grant is held indefinitely. hold_timeout is constant 0 and the mask logic is absent.
// TESTING
//  Reset, then req_ready=4'b0001, INTERVAL=5
//   -> grant=0001 on 1st edge; ready_waited=1 while req held; drop req -> busy=1 for 5 GAP cycles then 0.
//  All req_ready=4'b1111 held high, each granted requester drops ready after 3 cycles
//   -> grant_id sequence 0,1,2,3,0; successive grants start exactly 3+INTERVAL+1 cycles apart.
//  INTERVAL=0 and INTERVAL=1 -> GAP lasts exactly 1 cycle in both cases; next grant is 2 cycles after release.
//  Change INTERVAL 10->2 in the middle of a GAP -> that GAP still lasts 10 cycles; the next GAP lasts 2.
//  rst_n low for 1 cycle during GRANT and again during GAP
//   -> all outputs 0 next edge; pending req granted 1 cycle after rst_n high, no gap.
//  With macro, MAX_HOLD=8, req 2 held high forever
//   -> hold_timeout pulse after 8 GRANT cycles; req 2 not regranted until it drops; req 3 served next.

Source files
------------

// File: rtl/send_slot_arbiter.sv
// Round-robin owner of the shared send path with a guard gap after each release.
// Optional forced release after MAX_HOLD cycles: define SEND_ARB_HOLD_TIMEOUT_EN.
module send_slot_arbiter #(
   parameter int N_REQ    = 4,
   parameter int ID_W     = 2,
   parameter int MAX_HOLD = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      INTERVAL,
   input  logic [N_REQ-1:0] req_ready,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_id,
   output logic             ready_waited,
   output logic             busy,
   output logic             hold_timeout
);

   if (ID_W != $clog2(N_REQ)) begin : g_bad_id_w
      $error("ID_W must equal clog2(N_REQ)");
   end
   if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
      $error("N_REQ out of range");
   end
   if (MAX_HOLD < 1) begin : g_bad_max_hold
      $error("MAX_HOLD must be at least 1");
   end

   typedef enum logic [2:0] {
      IDLE  = 3'b001,
      GRANT = 3'b010,
      GAP   = 3'b100
   } state_t;

   state_t           state, state_nx;
   logic [N_REQ-1:0] grant_nx;
   logic [ID_W-1:0]  id_nx;
   logic [ID_W-1:0]  last_id, last_nx;
   logic [31:0]      gap_cnt, gap_cnt_nx;
   logic [31:0]      ivl_q, ivl_nx;
   logic [31:0]      gap_lim;
   logic             busy_nx;
   logic [N_REQ-1:0] eligible;
   logic [ID_W-1:0]  win_id;
   logic             win_vld;

`ifdef SEND_ARB_HOLD_TIMEOUT_EN
   logic [31:0]      hold_cnt, hold_cnt_nx;
   logic [N_REQ-1:0] mask, mask_nx;
   logic             to_nx;

   assign eligible     = req_ready & ~mask;
`else
   assign eligible     = req_ready;
   assign hold_timeout = 1'b0;
`endif

   assign gap_lim      = (ivl_q == 32'd0) ? 32'd0 : ivl_q - 32'd1;
   assign ready_waited = req_ready[grant_id] & (state == GRANT);

   // Search starts just after the last winner and wraps.
   always_comb begin
      int idx;
      win_vld = 1'b0;
      win_id  = '0;
      idx     = 0;
      for (int j = 1; j <= N_REQ; j++) begin
         idx = (int'(last_id) + j) % N_REQ;
         if (!win_vld && eligible[idx]) begin
            win_vld = 1'b1;
            win_id  = ID_W'(idx);
         end
      end
   end

   always_comb begin
      state_nx   = state;
      grant_nx   = grant;
      id_nx      = grant_id;
      last_nx    = last_id;
      gap_cnt_nx = gap_cnt;
      ivl_nx     = ivl_q;
`ifdef SEND_ARB_HOLD_TIMEOUT_EN
      hold_cnt_nx = hold_cnt;
      mask_nx     = mask & req_ready;
      to_nx       = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (win_vld) begin
               state_nx         = GRANT;
               grant_nx         = '0;
               grant_nx[win_id] = 1'b1;
               id_nx            = win_id;
               last_nx          = win_id;
`ifdef SEND_ARB_HOLD_TIMEOUT_EN
               hold_cnt_nx      = '0;
`endif
            end
         end
         GRANT: begin
            if (!req_ready[grant_id]) begin
               state_nx   = GAP;
               grant_nx   = '0;
               gap_cnt_nx = '0;
               ivl_nx     = INTERVAL;
            end
`ifdef SEND_ARB_HOLD_TIMEOUT_EN
            else if (hold_cnt == 32'(MAX_HOLD - 1)) begin
               state_nx          = GAP;
               grant_nx          = '0;
               gap_cnt_nx        = '0;
               ivl_nx            = INTERVAL;
               to_nx             = 1'b1;
               mask_nx[grant_id] = 1'b1;
            end else begin
               hold_cnt_nx = hold_cnt + 32'd1;
            end
`endif
         end
         GAP: begin
            if (gap_cnt == gap_lim) begin
               state_nx = IDLE;
            end else begin
               gap_cnt_nx = gap_cnt + 32'd1;
            end
         end
         default: begin
            state_nx = IDLE;
            grant_nx = '0;
         end
      endcase
      busy_nx = (state_nx != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         grant    <= '0;
         grant_id <= '0;
         last_id  <= ID_W'(N_REQ - 1);
         busy     <= 1'b0;
         gap_cnt  <= '0;
         ivl_q    <= '0;
      end else begin
         state    <= state_nx;
         grant    <= grant_nx;
         grant_id <= id_nx;
         last_id  <= last_nx;
         busy     <= busy_nx;
         gap_cnt  <= gap_cnt_nx;
         ivl_q    <= ivl_nx;
      end
   end

`ifdef SEND_ARB_HOLD_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_cnt     <= '0;
         mask         <= '0;
         hold_timeout <= 1'b0;
      end else begin
         hold_cnt     <= hold_cnt_nx;
         mask         <= mask_nx;
         hold_timeout <= to_nx;
      end
   end
`endif

endmodule

// File: tb/tb_send_slot_arbiter.sv
// Scoreboard bench for send_slot_arbiter: timing model of grants and gaps,
// directed scenarios followed by randomized requester traffic.
module tb_send_slot_arbiter;
   localparam int N    = 4;
   localparam int MAXH = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [31:0]   interval = 32'd5;
   logic [N-1:0]  req = '0;
   logic [N-1:0]  grant;
   logic [1:0]    grant_id;
   logic          ready_waited;
   logic          busy;
   logic          hold_timeout;

   always #5 clk = ~clk;

   send_slot_arbiter #(
      .N_REQ(N), .ID_W(2), .MAX_HOLD(MAXH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .INTERVAL(interval),
      .req_ready(req),
      .grant(grant),
      .grant_id(grant_id),
      .ready_waited(ready_waited),
      .busy(busy),
      .hold_timeout(hold_timeout)
   );

   typedef struct {
      int cyc;
      int id;
   } ev_t;

   typedef struct {
      int           cyc;
      logic [N-1:0] grant;
      logic         rw;
      logic         busy;
      logic         to;
   } st_t;

   ev_t evq[$];
   st_t stq[$];
   int  tests = 0;
   int  fails = 0;
   int  cyc = 0;

   // reference: who owns the path, and the first edge a new grant may occur
   int           owner = -1;
   int           last = N - 1;
   int           gstart = 0;
   longint       free_at = 0;
   logic [N-1:0] mask = '0;
   logic         exp_to = 1'b0;

   bit act[N];
   int hold[N];
   int relax[N];
   int cool[N];

   task automatic release_path();
      longint gap;
      gap = {32'd0, interval};
      if (gap == 0) gap = 1;
      free_at = longint'(cyc) + gap + 1;
      owner = -1;
   endtask

   task automatic model_edge();
      logic [N-1:0] elig;
      int id;
      exp_to = 1'b0;
      if (!rst_n) begin
         owner = -1;
         last = N - 1;
         free_at = longint'(cyc) + 1;
         mask = '0;
         return;
      end
`ifdef SEND_ARB_HOLD_TIMEOUT_EN
      mask = mask & req;
`endif
      if (owner >= 0) begin
         if (!req[owner]) begin
            release_path();
         end
`ifdef SEND_ARB_HOLD_TIMEOUT_EN
         else if (cyc - gstart == MAXH) begin
            mask[owner] = 1'b1;
            exp_to = 1'b1;
            release_path();
         end
`endif
      end else if (longint'(cyc) >= free_at) begin
         elig = req & ~mask;
         for (int j = 1; j <= N; j++) begin
            id = (last + j) % N;
            if (owner < 0 && elig[id]) begin
               owner = id;
               last = id;
               gstart = cyc;
               evq.push_back('{cyc: cyc, id: id});
            end
         end
      end
   endtask

   task automatic drive_req();
      for (int i = 0; i < N; i++) begin
         if (!act[i]) begin
            req[i] = 1'b0;
         end else if (owner == i) begin
            if (req[i] && hold[i] > 0 && cyc - gstart >= hold[i] - 1) begin
               req[i] = 1'b0;
               cool[i] = relax[i];
            end
         end else if (cool[i] > 0) begin
            cool[i]--;
            req[i] = 1'b0;
         end else begin
            req[i] = 1'b1;
         end
      end
   endtask

   task automatic cycle();
      st_t s;
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      drive_req();
      s.cyc = cyc;
      s.grant = '0;
      if (owner >= 0) s.grant[owner] = 1'b1;
      s.rw = (owner >= 0) && req[owner];
      s.busy = (owner >= 0) || (longint'(cyc) < free_at - 1);
      s.to = exp_to;
      stq.push_back(s);
   endtask

   task automatic run(input int n);
      for (int t = 0; t < n; t++) cycle();
   endtask

   task automatic quiet();
      for (int i = 0; i < N; i++) begin
         act[i] = 1'b0;
         cool[i] = 0;
         relax[i] = 0;
         hold[i] = 3;
      end
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [N-1:0] prev;
      st_t s;
      ev_t e;
      prev = '0;
      forever begin
         @(negedge clk);
         if (stq.size() > 0) begin
            s = stq.pop_front();
            tests++;
            if (grant !== s.grant || ready_waited !== s.rw ||
                busy !== s.busy || hold_timeout !== s.to ||
                (s.grant != '0 && grant[grant_id] !== 1'b1)) begin
               fails++;
               $display("FAIL status cyc=%0d grant=%b want %b id=%0d rw=%b want %b busy=%b want %b to=%b want %b",
                        s.cyc, grant, s.grant, grant_id, ready_waited, s.rw,
                        busy, s.busy, hold_timeout, s.to);
            end
         end
         if (grant != '0 && prev == '0) begin
            tests++;
            if (evq.size() == 0) begin
               fails++;
               $display("FAIL grant_event cyc=%0d id=%0d but no grant expected", cyc, grant_id);
            end else begin
               e = evq.pop_front();
               if (e.cyc != cyc || int'(grant_id) != e.id) begin
                  fails++;
                  $display("FAIL grant_event cyc=%0d id=%0d want cyc=%0d id=%0d",
                           cyc, grant_id, e.cyc, e.id);
               end
            end
         end
         prev = grant;
      end
   end

   initial begin
      quiet();
      rst_n = 1'b0;
      interval = 32'd5;
      run(3);
      rst_n = 1'b1;

      // single requester, 5-cycle gap
      act[0] = 1'b1; hold[0] = 4; relax[0] = 1000;
      run(16);
      quiet(); run(10);

      // all requesting, 3-cycle holds: order 0,1,2,3,0
      for (int i = 0; i < N; i++) begin
         act[i] = 1'b1; hold[i] = 3;
      end
      run(50);
      quiet(); run(10);

      // minimal gaps
      interval = 32'd0;
      for (int i = 0; i < N; i++) begin
         act[i] = 1'b1; hold[i] = 1 + i;
      end
      run(24);
      interval = 32'd1;
      run(24);
      quiet(); run(6);

      // INTERVAL changed mid-gap
      interval = 32'd10;
      act[1] = 1'b1; hold[1] = 2; relax[1] = 3;
      run(7);
      interval = 32'd2;
      run(30);
      quiet(); run(14);

      // reset during GRANT and during GAP
      interval = 32'd4;
      for (int i = 0; i < N; i++) begin
         act[i] = 1'b1; hold[i] = 6;
      end
      for (int t = 0; t < 40 && owner < 0; t++) cycle();
      run(2);
      pulse_reset();
      run(4);
      for (int t = 0; t < 40 && !(owner < 0 && longint'(cyc) < free_at - 1); t++) cycle();
      pulse_reset();
      run(12);
      quiet(); run(8);

      // largest gap: busy must stay high
      interval = 32'hFFFF_FFFF;
      act[0] = 1'b1; hold[0] = 2; relax[0] = 1000;
      run(40);
      quiet();
      pulse_reset();
      interval = 32'd2;

      // requester 2 never lets go, requester 3 waiting
      act[2] = 1'b1; hold[2] = 0;
      act[3] = 1'b1; hold[3] = 3; relax[3] = 100;
      run(40);
      act[2] = 1'b0;
      run(2);
      act[2] = 1'b1; hold[2] = 2;
      run(30);
      quiet(); run(8);

      // random traffic
      for (int blk = 0; blk < 60; blk++) begin
         interval = 32'($urandom_range(0, 6));
         for (int i = 0; i < N; i++) begin
            act[i] = ($urandom_range(0, 3) != 0);
            hold[i] = $urandom_range(1, 12);
            relax[i] = $urandom_range(0, 5);
         end
         for (int t = 0; t < 50; t++) begin
            if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            cycle();
         end
      end
      rst_n = 1'b1;
      quiet(); run(20);

      @(negedge clk);
      #1;
      tests++;
      if (evq.size() != 0 || stq.size() != 0) begin
         fails++;
         $display("FAIL drain pending_grants=%0d pending_status=%0d want 0 and 0",
                  evq.size(), stq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
